cmd_read: RTL and testbench

//  Receives SD card responses on the CMD line, the counterpart of the host command transmitter.

---
 rtl/cmd_read.sv | 151 +++++++++++++++
 tb/tb_cmd_read.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_read.sv
// SD CMD-line response receiver: waits for a start bit within the Ncr window, then
// shifts in a 48- or 136-bit response and checks transmission bit, end bit and CRC7.
module cmd_read #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_p_i,
    input  logic         cmd_i,
    input  logic         start_rx_i,
    input  logic         long_resp_i,
    input  logic         check_crc_i,
    output logic         busy_o,
    output logic         rx_done_o,
    output logic [119:0] resp_o,
    output logic [5:0]   index_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         frame_err_o
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_wait_cnt;
    logic [7:0]     r_bit_cnt;
    logic           r_long;
    logic           r_check_crc;
    // Bit k of the response (k >= 1) sits in r_shift[k-1] once the final bit arrives on
    // cmd_i; the start bit is known to be 0 and is not stored.
    logic [133:0]   r_shift;
    logic [6:0]     r_crc;
    logic [119:0]   r_resp;
    logic [5:0]     r_index;
    logic           r_timeout_err;
    logic           r_crc_err;
    logic           r_frame_err;

    logic           w_accept;
    logic [7:0]     w_wait_next;
    logic           w_timeout;
    logic [7:0]     w_bit_idx;
    logic           w_last_bit;
    logic           w_crc_en;
    logic           w_crc_fb;
    logic [6:0]     w_crc_next;

    assign w_accept    = (r_state == IDLE) && start_rx_i;
    assign w_wait_next = r_wait_cnt + 8'd1;
    assign w_timeout   = (w_wait_next == LP_TIMEOUT);
    assign w_bit_idx   = r_bit_cnt + 8'd1;
    assign w_last_bit  = (w_bit_idx == (r_long ? 8'd136 : 8'd48));
    assign w_crc_en    = r_long ? ((w_bit_idx >= 8'd9) && (w_bit_idx <= 8'd128))
                                : (w_bit_idx <= 8'd40);
    assign w_crc_fb    = r_crc[6] ^ cmd_i;
    assign w_crc_next  = {r_crc[5:3], r_crc[2] ^ w_crc_fb, r_crc[1:0], w_crc_fb};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_rx_i) w_state_next = WAIT_START;
            end
            WAIT_START: begin
                // The timeout edge wins over a start bit seen on that same edge.
                if (clk_en_p_i) begin
                    if (w_timeout)   w_state_next = DONE;
                    else if (!cmd_i) w_state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (clk_en_p_i && w_last_bit) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_long        <= 1'b0;
            r_check_crc   <= 1'b0;
            r_shift       <= '0;
            r_crc         <= '0;
            r_resp        <= '0;
            r_index       <= '0;
            r_timeout_err <= 1'b0;
            r_crc_err     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_long        <= long_resp_i;
                r_check_crc   <= check_crc_i;
                r_wait_cnt    <= '0;
                r_bit_cnt     <= '0;
                r_crc         <= '0;
                r_timeout_err <= 1'b0;
                r_crc_err     <= 1'b0;
                r_frame_err   <= 1'b0;
            end else if (clk_en_p_i && (r_state == WAIT_START)) begin
                r_wait_cnt <= w_wait_next;
                if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end else if (!cmd_i) begin
                    r_bit_cnt <= 8'd1;
                    r_crc     <= '0;
                end
            end else if (clk_en_p_i && (r_state == RECEIVE)) begin
                r_shift   <= {r_shift[132:0], cmd_i};
                r_bit_cnt <= w_bit_idx;
                if (w_crc_en) r_crc <= w_crc_next;
                if (w_last_bit) begin
                    if (r_long) begin
                        r_resp      <= r_shift[126:7];
                        r_index     <= '0;
                        r_frame_err <= r_shift[133] | ~cmd_i;
                    end else begin
                        r_resp      <= {88'b0, r_shift[38:7]};
                        r_index     <= r_shift[44:39];
                        r_frame_err <= r_shift[45] | ~cmd_i;
                    end
                    r_crc_err <= r_check_crc && (r_crc != r_shift[6:0]);
                end
            end
        end
    end

    assign busy_o        = (r_state == WAIT_START) || (r_state == RECEIVE);
    assign rx_done_o     = (r_state == DONE);
    assign resp_o        = r_resp;
    assign index_o       = r_index;
    assign timeout_err_o = r_timeout_err;
    assign crc_err_o     = r_crc_err;
    assign frame_err_o   = r_frame_err;

endmodule

// File: tb/tb_cmd_read.sv
// Self-checking bench for cmd_read: per-transaction reference model derived from the
// response frame bits, compared against the DUT outputs on every clock cycle.
module tb_cmd_read;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst, clk_en, cmd, start, lng, chk;
    logic         busy, done, to_err, crc_err, fr_err;
    logic [119:0] resp;
    logic [5:0]   idx;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic         exp_busy, exp_done, exp_to, exp_crc, exp_fr;
    logic [119:0] exp_resp;
    logic [5:0]   exp_idx;

    always #5 clk = ~clk;

    cmd_read #(.TimeoutCycles(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_en_p_i   (clk_en),
        .cmd_i        (cmd),
        .start_rx_i   (start),
        .long_resp_i  (lng),
        .check_crc_i  (chk),
        .busy_o       (busy),
        .rx_done_o    (done),
        .resp_o       (resp),
        .index_o      (idx),
        .timeout_err_o(to_err),
        .crc_err_o    (crc_err),
        .frame_err_o  (fr_err)
    );

    task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("busy_o", 120'(busy), 120'(exp_busy));
            check("rx_done_o", 120'(done), 120'(exp_done));
            check("resp_o", resp, exp_resp);
            check("index_o", 120'(idx), 120'(exp_idx));
            check("timeout_err_o", 120'(to_err), 120'(exp_to));
            check("crc_err_o", 120'(crc_err), 120'(exp_crc));
            check("frame_err_o", 120'(fr_err), 120'(exp_fr));
        end
    end

    // CRC7 (x^7+x^3+1, init 0) over frame bits r[hi] down to r[lo].
    function automatic logic [6:0] crc7_range(input logic [135:0] r, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int k = hi; k >= lo; k--) begin
            fb = c[6] ^ r[k];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [135:0] mk_short(input logic tx, input logic [5:0] ix,
                                             input logic [31:0] arg, input logic endb);
        logic [135:0] r;
        r         = '0;
        r[47:40]  = {1'b0, tx, ix};
        r[39:8]   = arg;
        r[7:1]    = crc7_range(r, 47, 8);
        r[0]      = endb;
        return r;
    endfunction

    function automatic logic [135:0] mk_long(input logic tx, input logic [119:0] cid,
                                            input logic endb);
        logic [135:0] r;
        r          = '0;
        r[134]     = tx;
        r[133:128] = 6'h3F;
        r[127:8]   = cid;
        r[7:1]     = crc7_range(r, 127, 8);
        r[0]       = endb;
        return r;
    endfunction

    task automatic model(input logic [135:0] r, input logic l, input logic c);
        if (l) begin
            exp_resp = r[127:8];
            exp_idx  = '0;
            exp_fr   = r[134] | ~r[0];
            exp_crc  = c && (crc7_range(r, 127, 8) != r[7:1]);
        end else begin
            exp_resp = {88'b0, r[39:8]};
            exp_idx  = r[45:40];
            exp_fr   = r[46] | ~r[0];
            exp_crc  = c && (crc7_range(r, 47, 8) != r[7:1]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random idle gap (random cmd, ignored start pulses) then one sampling strobe.
    task automatic strobe(input logic b);
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            clk_en = 1'b0;
            cmd    = 1'($urandom);
            start  = ($urandom_range(0, 7) == 0);
            tick();
        end
        clk_en = 1'b1;
        cmd    = b;
        start  = ($urandom_range(0, 7) == 0);
        tick();
        clk_en = 1'b0;
        start  = 1'b0;
    endtask

    task automatic arm(input logic l, input logic c);
        clk_en = 1'b0;
        start  = 1'b1;
        lng    = l;
        chk    = c;
        cmd    = 1'($urandom);
        tick();
        start    = 1'b0;
        lng      = 1'($urandom);
        chk      = 1'($urandom);
        exp_busy = 1'b1;
        exp_to   = 1'b0;
        exp_crc  = 1'b0;
        exp_fr   = 1'b0;
    endtask

    // DONE cycle: start pulse and strobe here must be ignored.
    task automatic done_cycle();
        exp_busy = 1'b0;
        exp_done = 1'b1;
        start    = 1'($urandom);
        clk_en   = 1'($urandom);
        cmd      = 1'($urandom);
        tick();
        start    = 1'b0;
        clk_en   = 1'b0;
        exp_done = 1'b0;
        tick();
    endtask

    task automatic do_rx(input logic [135:0] r, input logic l, input logic c, input int pre);
        int n;
        n = l ? 136 : 48;
        arm(l, c);
        repeat (pre) strobe(1'b1);
        for (int k = n - 1; k >= 0; k--) strobe(r[k]);
        model(r, l, c);
        done_cycle();
    endtask

    task automatic do_timeout(input logic last);
        arm(1'($urandom), 1'($urandom));
        repeat (TO - 1) strobe(1'b1);
        strobe(last);
        exp_to = 1'b1;
        done_cycle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [135:0] r;
        logic [127:0] rnd;
        logic         l, c;

        rst = 1'b1; clk_en = 1'b0; cmd = 1'b1; start = 1'b0; lng = 1'b0; chk = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_to = 1'b0; exp_crc = 1'b0; exp_fr = 1'b0;
        exp_resp = '0; exp_idx = '0;
        tick();
        checking = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Model pins: known CMD0 and CMD8 CRC bytes.
        r = mk_short(1'b1, 6'h00, 32'h0, 1'b1);
        check("pin_cmd0_frame", 120'(r[47:0]), 120'(48'h400000000095));
        r = '0;
        r[47:8] = 40'h48000001AA;
        check("pin_cmd8_crc", 120'(crc7_range(r, 47, 8)), 120'(7'h43));

        // CRC-valid frame with transmission bit set.
        r = '0;
        r[47:0] = 48'h400000000095;
        do_rx(r, 1'b0, 1'b1, 5);
        check("t1_frame_err", 120'(fr_err), 120'(1));
        check("t1_crc_err", 120'(crc_err), 120'(0));
        check("t1_index", 120'(idx), 120'(0));

        r = mk_short(1'b0, 6'h11, 32'h00000900, 1'b1);
        do_rx(r, 1'b0, 1'b1, 0);
        check("t2_index", 120'(idx), 120'(6'h11));
        check("t2_resp", resp, 120'(32'h00000900));
        check("t2_errs", 120'({to_err, crc_err, fr_err}), 120'(0));
        r[20] = ~r[20];
        do_rx(r, 1'b0, 1'b1, 3);
        check("t2b_errs", 120'({to_err, crc_err, fr_err}), 120'(3'b010));

        r = '0;
        r[47:0] = 48'h3F80FF8000FF;
        do_rx(r, 1'b0, 1'b0, 1);
        check("t3_resp", resp, 120'(32'h80FF8000));
        check("t3_index", 120'(idx), 120'(6'h3F));
        check("t3_crc_err", 120'(crc_err), 120'(0));

        // Timeout; start bit on the final strobe is too late.
        do_timeout(1'b0);
        check("t4_timeout", 120'(to_err), 120'(1));
        check("t4_resp_kept", resp, 120'(32'h80FF8000));
        // Start bit on the last strobe before timeout is still accepted.
        do_rx(mk_short(1'b0, 6'h2A, 32'hDEADBEEF, 1'b1), 1'b0, 1'b1, TO - 2);
        check("t4b_resp", resp, 120'(32'hDEADBEEF));

        r = mk_long(1'b0, 120'h1D4144534443415244107A0C00E4F3, 1'b1);
        do_rx(r, 1'b1, 1'b1, 2);
        check("t5_resp", resp, 120'h1D4144534443415244107A0C00E4F3);
        check("t5_errs", 120'({to_err, crc_err, fr_err}), 120'(0));
        r[0] = 1'b0;
        do_rx(r, 1'b1, 1'b1, 0);
        check("t5b_errs", 120'({to_err, crc_err, fr_err}), 120'(3'b001));

        // Reset in the middle of a frame.
        r = mk_short(1'b0, 6'h05, 32'h12345678, 1'b1);
        arm(1'b0, 1'b1);
        for (int k = 47; k >= 28; k--) strobe(r[k]);
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        exp_busy = 1'b0; exp_done = 1'b0; exp_to = 1'b0; exp_crc = 1'b0; exp_fr = 1'b0;
        exp_resp = '0; exp_idx = '0;
        #1;
        check("t6_busy_async", 120'(busy), 120'(0));
        check("t6_resp_async", resp, 120'(0));
        tick();
        rst = 1'b0;
        tick();
        do_rx(r, 1'b0, 1'b1, 4);
        check("t6_resp_after", resp, 120'(32'h12345678));

        // Randomized transactions.
        repeat (30) begin
            if ($urandom_range(0, 9) == 0) begin
                do_timeout(1'($urandom));
            end else begin
                l   = 1'($urandom);
                c   = 1'($urandom);
                rnd = {$urandom, $urandom, $urandom, $urandom};
                if (l) r = mk_long(($urandom_range(0, 5) == 0), rnd[119:0],
                                   ($urandom_range(0, 5) != 0));
                else   r = mk_short(($urandom_range(0, 5) == 0), rnd[37:32], rnd[31:0],
                                    ($urandom_range(0, 5) != 0));
                if ($urandom_range(0, 3) == 0) r[$urandom_range(1, l ? 133 : 45)] ^= 1'b1;
                do_rx(r, l, c, $urandom_range(0, TO - 2));
            end
        end

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
